// File: rtl/muxnx1_pkg.sv
// Shared definitions for the registered N-to-1 pipeline mux.
package muxnx1_pkg;

   // Occupancy of the output register (OR) and skid register (SK).
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,   // OR invalid
      ST_ONE   = 2'd1,   // OR valid, SK empty
      ST_FULL  = 2'd2    // OR and SK valid
   } state_t;

   // Select width: clog2(n), but never narrower than one bit.
   function automatic int sel_w(input int n);
      int w;
      w = $clog2(n);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/muxnx1_sel.sv
// Combinational decode: picks input[sel]; out-of-range selects give zero data
// with the error flag raised so the output is never X.
module muxnx1_sel
   import muxnx1_pkg::*;
#(
   parameter  int WIDTH = 32,
   parameter  int N_IN  = 4,
   localparam int SEL_W = sel_w(N_IN)
) (
   input  logic [N_IN*WIDTH-1:0] in_data,
   input  logic [SEL_W-1:0]      sel,
   output logic [WIDTH-1:0]      out_data,
   output logic                  out_sel_err
);

   // One masked word per input; at most one is non-zero.
   logic [WIDTH-1:0] w_terms [N_IN];

   for (genvar gi = 0; gi < N_IN; gi++) begin : g_term
      assign w_terms[gi] = (int'(sel) == gi) ? in_data[gi*WIDTH +: WIDTH] : '0;
   end

   // OR-reduce the masked words; an out-of-range select matches none and yields zero.
   always_comb begin
      out_data = '0;
      for (int i = 0; i < N_IN; i++) begin
         out_data = out_data | w_terms[i];
      end
   end

   assign out_sel_err = (int'(sel) >= N_IN);

endmodule

// File: rtl/muxnx1_pipe.sv
// Registered N-to-1 mux with valid/ready handshake, 2-entry skid storage,
// synchronous flush and a saturating out-of-range select counter.
module muxnx1_pipe
   import muxnx1_pkg::*;
#(
   parameter  int WIDTH = 32,
   parameter  int N_IN  = 4,
   parameter  int CNT_W = 8,
   localparam int SEL_W = sel_w(N_IN)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [N_IN*WIDTH-1:0] in_data,
   input  logic [SEL_W-1:0]      sel,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  flush,
   input  logic                  err_clr,
   output logic [WIDTH-1:0]      out_data,
   output logic                  out_sel_err,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  err_sticky,
   output logic [CNT_W-1:0]      err_count
);

   // A beat as stored: selected data plus its out-of-range flag. Kept local
   // because its width follows the WIDTH parameter of each instance.
   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic             sel_err;
   } beat_t;

   logic [WIDTH-1:0] w_sel_data;
   logic             w_sel_err;
   beat_t            w_new;
   logic             w_accept;
   logic             w_drain;
   state_t           w_state_next;
   logic             w_load_or;
   logic             w_load_sk;
   logic             w_sk_to_or;

   state_t           r_state;
   beat_t            r_or;
   beat_t            r_sk;
   logic             r_in_ready;
   logic             r_err_sticky;
   logic [CNT_W-1:0] r_err_count;

   muxnx1_sel #(
      .WIDTH (WIDTH),
      .N_IN  (N_IN)
   ) u_sel (
      .in_data     (in_data),
      .sel         (sel),
      .out_data    (w_sel_data),
      .out_sel_err (w_sel_err)
   );

   assign w_new    = '{data: w_sel_data, sel_err: w_sel_err};
   assign w_accept = in_valid & r_in_ready;
   assign w_drain  = (r_state != ST_EMPTY) & out_ready;

   // Next occupancy and which register loads what; FULL never accepts since in_ready=0.
   always_comb begin
      w_state_next = r_state;
      w_load_or    = 1'b0;
      w_load_sk    = 1'b0;
      w_sk_to_or   = 1'b0;
      case (r_state)
         ST_EMPTY: begin
            if (w_accept) begin
               w_state_next = ST_ONE;
               w_load_or    = 1'b1;
            end
         end
         ST_ONE: begin
            if (w_accept && !w_drain) begin
               w_state_next = ST_FULL;
               w_load_sk    = 1'b1;
            end else if (w_accept && w_drain) begin
               w_load_or    = 1'b1;
            end else if (w_drain) begin
               w_state_next = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (w_drain) begin
               w_state_next = ST_ONE;
               w_sk_to_or   = 1'b1;
            end
         end
         default: w_state_next = ST_EMPTY;
      endcase
   end

   // Storage and FSM update; flush empties the pipe but leaves OR contents visible.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= ST_EMPTY;
         r_in_ready <= 1'b1;
         r_or       <= '0;
         r_sk       <= '0;
      end else if (flush) begin
         r_state    <= ST_EMPTY;
         r_in_ready <= 1'b1;
      end else begin
         r_state    <= w_state_next;
         // Registered ready: no combinational path from out_ready.
         r_in_ready <= (w_state_next != ST_FULL);
         if (w_load_or) begin
            r_or <= w_new;
         end else if (w_sk_to_or) begin
            r_or <= r_sk;
         end
         if (w_load_sk) begin
            r_sk <= w_new;
         end
      end
   end

   // Sticky flag and saturating counter for accepted out-of-range selects; clear wins.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_err_sticky <= 1'b0;
         r_err_count  <= '0;
      end else if (err_clr) begin
         r_err_sticky <= 1'b0;
         r_err_count  <= '0;
      end else if (w_accept && w_sel_err && !flush) begin
         r_err_sticky <= 1'b1;
         if (r_err_count != '1) begin
            r_err_count <= r_err_count + 1'b1;
         end
      end
   end

   assign in_ready    = r_in_ready;
   assign out_valid   = (r_state != ST_EMPTY);
   assign out_data    = r_or.data;
   assign out_sel_err = r_or.sel_err;
   assign err_sticky  = r_err_sticky;
   assign err_count   = r_err_count;

endmodule

// File: tb/tb_muxnx1_pipe.sv
// Self-checking bench for muxnx1_pipe: directed scenarios plus random stress,
// compared every cycle against a queue-based reference model.
module tb_muxnx1_pipe;

   localparam int WIDTH = 32;
   localparam int N_IN  = 3;
   localparam int CNT_W = 2;
   localparam int SEL_W = 2;

   localparam logic [31:0] A = 32'h1111_1111;
   localparam logic [31:0] B = 32'h2222_2222;
   localparam logic [31:0] C = 32'h3333_3333;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic [N_IN*WIDTH-1:0] in_data;
   logic [SEL_W-1:0]      sel;
   logic                  in_valid;
   logic                  in_ready;
   logic                  flush;
   logic                  err_clr;
   logic [WIDTH-1:0]      out_data;
   logic                  out_sel_err;
   logic                  out_valid;
   logic                  out_ready;
   logic                  err_sticky;
   logic [CNT_W-1:0]      err_count;

   always #5 clk = ~clk;

   muxnx1_pipe #(
      .WIDTH (WIDTH),
      .N_IN  (N_IN),
      .CNT_W (CNT_W)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_data     (in_data),
      .sel         (sel),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .flush       (flush),
      .err_clr     (err_clr),
      .out_data    (out_data),
      .out_sel_err (out_sel_err),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .err_sticky  (err_sticky),
      .err_count   (err_count)
   );

   int total = 0;
   int bad   = 0;
   bit verbose = 1'b1;

   // Reference model: beats held in the block as a FIFO of {data, sel_err}.
   logic [32:0] m_q[$];
   logic [31:0] m_or_data;
   logic        m_or_err;
   logic        m_in_ready;
   logic        m_sticky;
   int          m_cnt;
   logic [31:0] words [N_IN];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [32:0] ref_beat(input logic [SEL_W-1:0] s);
      int idx;
      idx = int'(s);
      if (idx < N_IN) return {words[idx], 1'b0};
      return {32'h0, 1'b1};
   endfunction

   // Drive one cycle of inputs, advance the model at the edge, check all outputs.
   task automatic step(input logic v, input logic [SEL_W-1:0] s, input logic ordy,
                       input logic fl, input logic ec, input logic rn);
      logic        acc;
      logic        dr;
      logic [32:0] tmp;
      in_valid  = v;
      sel       = s;
      out_ready = ordy;
      flush     = fl;
      err_clr   = ec;
      rst_n     = rn;
      in_data   = {words[2], words[1], words[0]};
      @(posedge clk);
      if (!rn) begin
         m_q.delete();
         m_or_data  = '0;
         m_or_err   = 1'b0;
         m_in_ready = 1'b1;
         m_sticky   = 1'b0;
         m_cnt      = 0;
      end else begin
         acc = v & m_in_ready & ~fl;
         dr  = ordy & (m_q.size() > 0);
         if (fl) begin
            m_q.delete();
         end else begin
            if (dr) begin
               tmp = m_q.pop_front();
               if (verbose) $display("beat out: data=%h sel_err=%b", tmp[32:1], tmp[0]);
            end
            if (acc) begin
               m_q.push_back(ref_beat(s));
               if (verbose) $display("beat in : sel=%0d", s);
            end
         end
         if (m_q.size() > 0) {m_or_data, m_or_err} = m_q[0];
         m_in_ready = (m_q.size() < 2);
         if (ec) begin
            m_sticky = 1'b0;
            m_cnt    = 0;
         end else if (acc && int'(s) >= N_IN) begin
            m_sticky = 1'b1;
            if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
         end
      end
      #1;
      chk("in_ready",    32'(in_ready),    32'(m_in_ready));
      chk("out_valid",   32'(out_valid),   32'(m_q.size() > 0));
      chk("out_data",    out_data,         m_or_data);
      chk("out_sel_err", 32'(out_sel_err), 32'(m_or_err));
      chk("err_sticky",  32'(err_sticky),  32'(m_sticky));
      chk("err_count",   32'(err_count),   32'(m_cnt));
   endtask

   initial begin
      words[0] = A;
      words[1] = B;
      words[2] = C;
      m_or_data = '0; m_or_err = 1'b0; m_in_ready = 1'b1; m_sticky = 1'b0; m_cnt = 0;

      // Reset
      step(0, 0, 1, 0, 0, 0);
      step(0, 0, 1, 0, 0, 0);
      chk("rst_in_ready",  32'(in_ready),  32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data",  out_data,       32'd0);
      chk("rst_err_count", 32'(err_count), 32'd0);

      // Single beat, one-cycle latency
      step(1, 1, 1, 0, 0, 1);
      chk("single_valid", 32'(out_valid),   32'd1);
      chk("single_data",  out_data,         B);
      chk("single_err",   32'(out_sel_err), 32'd0);
      step(0, 0, 1, 0, 0, 1);
      chk("single_once",  32'(out_valid),   32'd0);

      // Backpressure: fill OR and SK, then drain in order
      step(1, 0, 0, 0, 0, 1);
      step(1, 1, 0, 0, 0, 1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_hold_A",   out_data,      A);
      step(1, 2, 0, 0, 0, 1);
      chk("bp_stall_A",  out_data,      A);
      step(1, 2, 1, 0, 0, 1);
      chk("bp_out_B",    out_data,      B);
      step(1, 2, 1, 0, 0, 1);
      chk("bp_out_C",    out_data,      C);
      step(0, 0, 1, 0, 0, 1);
      chk("bp_drained",  32'(out_valid), 32'd0);

      // Out-of-range selects, counter saturation, clear
      for (int i = 0; i < 3; i++) step(1, 3, 1, 0, 0, 1);
      chk("oor_cnt3",    32'(err_count),   32'd3);
      step(1, 3, 1, 0, 0, 1);
      step(1, 3, 1, 0, 0, 1);
      chk("oor_sat",     32'(err_count),   32'd3);
      chk("oor_sticky",  32'(err_sticky),  32'd1);
      chk("oor_data",    out_data,         32'd0);
      chk("oor_flag",    32'(out_sel_err), 32'd1);
      step(1, 3, 1, 0, 1, 1);
      chk("clr_count",   32'(err_count),   32'd0);
      chk("clr_sticky",  32'(err_sticky),  32'd0);
      step(0, 0, 1, 0, 0, 1);

      // Flush while FULL with a beat presented
      step(1, 3, 0, 0, 0, 1);
      step(1, 0, 0, 0, 0, 1);
      step(1, 2, 0, 1, 0, 1);
      chk("fl_valid",    32'(out_valid), 32'd0);
      chk("fl_in_ready", 32'(in_ready),  32'd1);
      chk("fl_cnt",      32'(err_count), 32'd1);
      step(0, 0, 1, 0, 0, 1);
      step(0, 0, 1, 0, 0, 1);
      chk("fl_no_ghost", 32'(out_valid), 32'd0);

      // Reset while FULL
      step(1, 0, 0, 0, 0, 1);
      step(1, 1, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0);
      chk("mrst_valid",  32'(out_valid),  32'd0);
      chk("mrst_ready",  32'(in_ready),   32'd1);
      chk("mrst_data",   out_data,        32'd0);
      chk("mrst_sticky", 32'(err_sticky), 32'd0);
      step(1, 0, 1, 0, 0, 1);
      chk("post_rst_A",  out_data,        A);
      step(0, 0, 1, 0, 0, 1);

      // Random stress
      verbose = 1'b0;
      for (int i = 0; i < 10000; i++) begin
         for (int w = 0; w < N_IN; w++) words[w] = $urandom;
         step(1'($urandom_range(0, 1)),
              2'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)),
              1'($urandom_range(0, 63) == 0),
              1'($urandom_range(0, 63) == 0),
              1'($urandom_range(0, 255) != 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
